// File: rtl/cast_port_arbiter_if.sv
// cast_port_arbiter_if
// Request/grant bundle between an output port's arbiter and the router.
//   master : router side, drives req_i, flit_type_i, flit_fire_i and
//            observes grant_o, busy_o, timeout_o, proto_err_o
//   slave  : arbiter side, the reverse
// NREQ sets the request/grant width (one bit per input channel).
interface cast_port_arbiter_if #(
    parameter int NREQ = 5
);
    logic [NREQ-1:0] req_i;
    logic [1:0]      flit_type_i;
    logic            flit_fire_i;
    logic [NREQ-1:0] grant_o;
    logic            busy_o;
    logic            timeout_o;
    logic            proto_err_o;

    modport master (
        output req_i, flit_type_i, flit_fire_i,
        input  grant_o, busy_o, timeout_o, proto_err_o
    );

    modport slave (
        input  req_i, flit_type_i, flit_fire_i,
        output grant_o, busy_o, timeout_o, proto_err_o
    );
endinterface

// File: rtl/cast_port_arbiter.sv
// cast_port_arbiter
// Packet-level round-robin arbiter for one router output port. The grant is
// locked from head flit to tail flit (wormhole switching). After a release
// the released requester drops to lowest priority.
// Ports:
//   clk        router clock
//   rstn       asynchronous active-low reset
//   bus.slave  req_i (level requests), flit_type_i / flit_fire_i (port
//              output flit type and fire), grant_o (one-hot, registered),
//              busy_o (locked), timeout_o (watchdog release pulse),
//              proto_err_o (sticky: fire seen while idle)
// Build option: CAST_ARB_TIMEOUT_EN enables a watchdog that force-releases a
// lock after TIMEOUT cycles without a fire. Without it timeout_o is 0.
module cast_port_arbiter #(
    parameter int NREQ    = 5,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rstn,
    cast_port_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [NREQ-1:0] grant_q;
    logic            busy_q;
    logic            perr_q;

    logic [PW-1:0]   win;
    logic            found;
    logic            tail_fire;
    logic            wd_hit;
    logic [PW-1:0]   ptr_nxt;

    // Round-robin search: first set request at or above ptr, wrapping.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && bus.req_i[j]) begin
                found = 1'b1;
                win   = PW'(j);
            end
        end
    end

    // Tail (10) and single (11) both carry bit 1; either ends the packet.
    assign tail_fire = bus.flit_fire_i & bus.flit_type_i[1];
    assign ptr_nxt   = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);

`ifdef CAST_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] wd_cnt;
    logic          tmo_q;

    // A tail fire at the limit wins: fire suppresses the watchdog.
    assign wd_hit        = (state == LOCKED) && !bus.flit_fire_i &&
                           (wd_cnt == CW'(TIMEOUT));
    assign bus.timeout_o = tmo_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_cnt <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tmo_q <= wd_hit;
            if (state != LOCKED || bus.flit_fire_i || wd_hit)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + CW'(1);
        end
    end
`else
    assign wd_hit        = 1'b0;
    // TIMEOUT only matters when the watchdog is built in.
    assign bus.timeout_o = 1'b0 & (TIMEOUT == 0);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.flit_fire_i) perr_q <= 1'b1;
                    if (found) begin
                        state   <= LOCKED;
                        owner   <= win;
                        grant_q <= NREQ'(1) << win;
                        busy_q  <= 1'b1;
                    end
                end
                LOCKED: begin
                    // req_i is ignored while locked; only a tail fire or
                    // the watchdog ends the lock.
                    if (tail_fire || wd_hit) begin
                        state   <= IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        ptr     <= ptr_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant_o     = grant_q;
    assign bus.busy_o      = busy_q;
    assign bus.proto_err_o = perr_q;
endmodule

// File: tb/tb_cast_port_arbiter.sv
module tb_cast_port_arbiter;
    localparam int N   = 5;
    localparam int TMO = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    cast_port_arbiter_if #(.NREQ(N)) bus();
    cast_port_arbiter #(.NREQ(N), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: owner index (-1 idle), pointer, idle-fire flag, watchdog.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    bit m_tmo   = 0;
    bit m_perr  = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] m_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic m_reset();
        m_owner = -1; m_ptr = 0; m_cnt = 0; m_tmo = 0; m_perr = 0;
    endtask

    task automatic m_release();
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
    endtask

    task automatic m_step(logic [N-1:0] req, logic [1:0] ft, logic fire);
        bit found;
        m_tmo = 0;
        if (m_owner < 0) begin
            if (fire) m_perr = 1;
            found = 0;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!found && req[j]) begin
                    found = 1; m_owner = j; m_cnt = 0;
                end
            end
        end else if (fire && (ft == 2'b10 || ft == 2'b11)) begin
            m_release();
        end else if (fire) begin
            m_cnt = 0;
        end else begin
`ifdef CAST_ARB_TIMEOUT_EN
            if (m_cnt == TMO) begin
                m_release(); m_tmo = 1;
            end else m_cnt++;
`endif
        end
    endtask

    task automatic check_outs(string tag);
        chk({tag, ".grant"}, 32'(bus.grant_o), 32'(m_grant()));
        chk({tag, ".busy"},  32'(bus.busy_o), 32'(m_owner >= 0));
        chk({tag, ".tmo"},   32'(bus.timeout_o), 32'(m_tmo));
        chk({tag, ".perr"},  32'(bus.proto_err_o), 32'(m_perr));
    endtask

    // One clock: drive inputs, advance model on the edge, check 1 after it.
    task automatic cyc(logic [N-1:0] req, logic [1:0] ft, logic fire, string tag);
        bus.req_i = req; bus.flit_type_i = ft; bus.flit_fire_i = fire;
        @(posedge clk);
        m_step(req, ft, fire);
        #1;
        check_outs(tag);
    endtask

    task automatic drain(string tag);
        for (int i = 0; i < 20 && m_owner >= 0; i++) cyc('0, 2'b10, 1'b1, tag);
        chk({tag, ".drained"}, 32'(m_owner >= 0), 32'd0);
    endtask

    logic [N-1:0] seen[$];
    logic [N-1:0] exp_ord[4];
    int           pulses;
    logic         was_busy;

    initial begin
        bus.req_i = '0; bus.flit_type_i = '0; bus.flit_fire_i = 1'b0;
        m_reset();
        #3 check_outs("reset");
        #9 rstn = 1'b1;

        // Round-robin order with single-flit packets fired on every grant cycle.
        exp_ord = '{5'b00010, 5'b00100, 5'b10000, 5'b00010};
        was_busy = 1'b0;
        for (int i = 0; i < 40 && seen.size() < 4; i++) begin
            cyc(5'b10110, 2'b11, m_owner >= 0, "rr");
            if (bus.busy_o && !was_busy) seen.push_back(bus.grant_o);
            was_busy = bus.busy_o;
        end
        chk("rr.count", 32'(seen.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen.size(); i++) chk("rr.order", 32'(seen[i]), 32'(exp_ord[i]));
        drain("rr");

        // Lock hold on requester 1 despite request changes and stalls.
        cyc(5'b00010, 2'b00, 1'b0, "lk");
        chk("lk.g0", 32'(bus.grant_o), 32'h02);
        cyc(5'b11111, 2'b01, 1'b1, "lk"); chk("lk.head", 32'(bus.grant_o), 32'h02);
        cyc(5'b11111, 2'b00, 1'b1, "lk"); chk("lk.body", 32'(bus.grant_o), 32'h02);
        cyc(5'b11101, 2'b00, 1'b0, "lk"); chk("lk.stall", 32'(bus.grant_o), 32'h02);
        cyc(5'b11101, 2'b00, 1'b0, "lk"); chk("lk.stall", 32'(bus.grant_o), 32'h02);
        cyc(5'b11101, 2'b00, 1'b1, "lk"); chk("lk.body2", 32'(bus.grant_o), 32'h02);
        cyc(5'b11101, 2'b10, 1'b1, "lk"); chk("lk.rel", 32'(bus.grant_o), 32'h00);

        // Wrap: release 3 puts ptr at 4, then 4 before 0.
        cyc(5'b01000, 2'b00, 1'b0, "wr"); chk("wr.g3", 32'(bus.grant_o), 32'h08);
        cyc(5'b01000, 2'b11, 1'b1, "wr");
        cyc(5'b10001, 2'b00, 1'b0, "wr"); chk("wr.g4", 32'(bus.grant_o), 32'h10);
        cyc(5'b10001, 2'b11, 1'b1, "wr");
        cyc(5'b10001, 2'b00, 1'b0, "wr"); chk("wr.g0", 32'(bus.grant_o), 32'h01);
        cyc(5'b10001, 2'b11, 1'b1, "wr");

        // Watchdog: head fire then silence.
        cyc(5'b00110, 2'b00, 1'b0, "wd"); chk("wd.g1", 32'(bus.grant_o), 32'h02);
        cyc(5'b00110, 2'b01, 1'b1, "wd");
        pulses = 0;
`ifdef CAST_ARB_TIMEOUT_EN
        for (int i = 0; i < 6; i++) begin
            cyc(5'b00110, 2'b00, 1'b0, "wd");
            if (bus.timeout_o) begin
                pulses++;
                chk("wd.gz", 32'(bus.grant_o), 32'h00);
            end
        end
        chk("wd.pulses", 32'(pulses), 32'd1);
        cyc(5'b00110, 2'b00, 1'b0, "wd"); chk("wd.next", 32'(bus.grant_o), 32'h04);
`else
        for (int i = 0; i < 100; i++) begin
            cyc(5'b00110, 2'b00, 1'b0, "wd");
            if (bus.timeout_o) pulses++;
        end
        chk("wd.pulses", 32'(pulses), 32'd0);
        chk("wd.held", 32'(bus.grant_o), 32'h02);
`endif
        drain("wd");

        // Random traffic.
        begin
            logic [N-1:0] r;
            r = N'($urandom_range(0, 31));
            for (int i = 0; i < 400; i++) begin
                logic f;
                if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 31));
                f = (m_owner >= 0) && ($urandom_range(0, 1) == 1);
                cyc(r, 2'($urandom_range(0, 3)), f, "rnd");
            end
        end
        drain("rnd");

        // Fire while idle is sticky through later packets.
        cyc('0, 2'b11, 1'b1, "pe"); chk("pe.set", 32'(bus.proto_err_o), 32'd1);
        cyc(5'b00100, 2'b00, 1'b0, "pe");
        cyc(5'b00100, 2'b11, 1'b1, "pe");
        cyc('0, 2'b00, 1'b0, "pe"); chk("pe.stick", 32'(bus.proto_err_o), 32'd1);

        // Async reset mid-packet, between edges.
        cyc(5'b01000, 2'b00, 1'b0, "ar");
        cyc(5'b01000, 2'b01, 1'b1, "ar");
        #2 rstn = 1'b0;
        m_reset();
        #1;
        chk("ar.grant", 32'(bus.grant_o), 32'h00);
        chk("ar.busy", 32'(bus.busy_o), 32'd0);
        chk("ar.perr", 32'(bus.proto_err_o), 32'd0);
        bus.flit_fire_i = 1'b0;
        @(posedge clk);
        #2 rstn = 1'b1;
        cyc(5'b10100, 2'b00, 1'b0, "ar");
        chk("ar.first", 32'(bus.grant_o), 32'h04);
        drain("ar");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule

// File: doc/cast_port_arbiter.md
# cast_port_arbiter

Packet-level round-robin arbiter for one output port of the cast router. It takes requests from the five input stages (local, west, east, vert0, vert1 = requester 0..4) and grants the port to one of them. The grant stays locked from the head flit through the tail flit, which gives wormhole switching. It drives the crossbar select for that port and watches the port's fire and flit-type signals to know when the packet has ended.

## Interface
Parameters:
- NREQ, 5, number of requesters; requester index matches router channel id
- TIMEOUT, 255, watchdog limit in cycles; must be >= 1; only used with CAST_ARB_TIMEOUT_EN

Ports:
- clk  in  1  router clock
- rstn  in  1  asynchronous active-low reset
- req_i  in  NREQ  per-requester request; level, held by the input stage while it has a packet for this port
- flit_type_i  in  2  type of the flit currently on this port's output, i.e. data_o[`DW-1:`DW-2]
- flit_fire_i  in  1  valid_o & ready_i on this output port
- grant_o  out  NREQ  one-hot registered grant (crossbar select); all-zero when idle
- busy_o  out  1  port locked to a packet
- timeout_o  out  1  one-cycle pulse when the watchdog force-releases a lock
- proto_err_o  out  1  sticky; set on a fire while idle

## Operation
- Flit type encoding: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single-flit (head+tail). A packet ends on tail or single.
- State IDLE:
  - If req_i != 0, the winner is the first set bit searching upward from ptr, wrapping NREQ-1 -> 0.
  - Next cycle: grant_o = onehot(winner), busy_o = 1, and the state moves to LOCKED.
- State LOCKED:
  - grant_o is held constant. Changes on req_i are ignored, including deassertion by the granted requester.
  - On flit_fire_i with type tail or single: next cycle grant_o = 0, busy_o = 0, ptr = (winner+1) mod NREQ, state IDLE.
  - Fire with head or body type: no state change.
- ptr changes only on release. After a release, the released requester has the lowest priority.
- proto_err_o: set when flit_fire_i = 1 in IDLE. Cleared only by reset.
- Reset mid-packet: all state is cleared immediately and asynchronously. There is no recovery of the in-flight packet.

## Timing
- Reset values: grant_o 0, busy_o 0, timeout_o 0, proto_err_o 0, ptr 0, watchdog count 0.
- Request to grant latency: 1 cycle. With req_i rising at edge n, grant_o is visible after edge n+1.
- Tail fire to release: grant_o drops after the same edge that samples the tail fire.
- Packet-to-packet gap: at least 1 idle cycle. The IDLE cycle after a release re-arbitrates, and the next grant appears one edge later. Maximum utilisation for single-flit packets is therefore 1 flit every 2 cycles.
- A fire of a single-flit packet on the first grant cycle releases after that edge.
- Outputs are all registered; there is no combinational path from inputs to outputs.

## Configuration
- CAST_ARB_TIMEOUT_EN defined:
  - An 8+ bit counter (width $clog2(TIMEOUT+1)) runs in LOCKED. It is cleared on any fire and on entering LOCKED.
  - When it reaches TIMEOUT without a fire, the next edge does all of the following: clears the lock, advances ptr past the winner, pulses timeout_o for one cycle, and enters IDLE.
  - A tail fire in the same cycle as the limit counts as a normal release; timeout_o stays 0.
- CAST_ARB_TIMEOUT_EN undefined: no counter logic, timeout_o tied to 0, and a lock is held indefinitely until a tail fire.

## Test plan
- Reset, then req_i = 5'b10110 held, with single-flit fires on every granted cycle. Required grant order: 00010, 00100, 10000, 00010, each separated by one idle cycle.
- Lock hold: grant to requester 1. Fire types head, body, body (with ready low for 2 cycles in between), then tail. Required: grant_o = 00010 throughout, even with req_i = 11111 and req_i[1] dropping mid-packet. grant_o = 0 the cycle after the tail.
- Wrap: ptr = 4 after a release of requester 3, req_i = 10001. Required: requester 4 is granted next, then requester 0.
- Protocol error: flit_fire_i = 1 while IDLE. Required: proto_err_o = 1 from the next cycle, and it stays set through later normal packets until rstn is pulsed.
- Timeout (macro on, TIMEOUT = 4): grant, head fire, then no fire for 4 cycles. Required: timeout_o pulses exactly once, grant_o = 0 on the same cycle, and the next requester is granted after that. Macro off: the same stimulus holds the grant for 100 cycles with timeout_o = 0.
- Async reset: assert rstn low mid-packet between clock edges. Required: grant_o and busy_o are 0 before the next edge, and the first grant after reset goes to the lowest requesting index.
